tm1638_key_reader: RTL and testbench

- Input-side companion of the TM1638 display path: serial master that periodically issues the TM1638 "read key scan" command (0x42) over STB/CLK/DIO.
- Reads the 4 scan bytes, maps them to the 8 HW-154 keys, debounces, and presents a stable key[7:0] to user logic.
- Shares STB/CLK/DIO with the display writer through a req/gnt arbiter handshake.

---
 rtl/tm1638_key_reader.sv | 265 ++++++++++++++++++++++++++
 tb/tb_tm1638_key_reader.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tm1638_key_reader.sv
// TM1638 key-scan reader: periodically issues the 0x42 read command on the shared STB/CLK/DIO
// bus, maps and debounces the 8 HW-154 keys. Define TM1638_KEY_EDGE_EN to add key_pressed[7:0].
module tm1638_key_reader #(
  parameter int CLK_DIV          = 16,
  parameter int TURNAROUND       = 32,
  parameter int POLL_INTERVAL    = 27000,
  parameter int DEBOUNCE_SAMPLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       bus_req,
  input  logic       bus_gnt,
  output logic       stb,
  output logic       sclk,
  output logic       dio_out,
  output logic       dio_oe,
  input  logic       dio_in,
  output logic [7:0] key,
  output logic       key_valid,
  output logic       key_changed,
`ifdef TM1638_KEY_EDGE_EN
  output logic [7:0] key_pressed,
`endif
  output logic [2:0] dbg_state_o
);

  localparam int TMAX_A = (POLL_INTERVAL > TURNAROUND) ? POLL_INTERVAL : TURNAROUND;
  localparam int TMAX   = (TMAX_A > CLK_DIV) ? TMAX_A : CLK_DIV;
  localparam int TW     = $clog2(TMAX + 1);

  localparam logic [TW-1:0] HALF_LAST = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURNAROUND - 1);
  localparam logic [TW-1:0] POLL_LAST = TW'(POLL_INTERVAL - 1);
  localparam logic [7:0]    CMD_READ  = 8'h42;
  localparam logic [3:0]    DEB_N     = 4'(DEBOUNCE_SAMPLES);

  typedef enum logic [2:0] {
    S_WAIT, S_REQ, S_SETUP, S_CMD, S_TURN, S_READ, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          half_q, half_d;
  logic [4:0]    bit_q, bit_d;
  logic [31:0]   shift_q, shift_d;
  logic          sync1_q, sync2_q;
  logic [7:0]    prev_raw_q, prev_raw_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    key_q, key_d;
  logic          key_valid_q, key_valid_d;
  logic          key_changed_q, key_changed_d;
  logic          stb_q, stb_d;
  logic          sclk_q, sclk_d;
  logic          dout_q, dout_d;
  logic          oe_q, oe_d;
  logic          req_q, req_d;
  logic          half_end;
  logic [4:0]    bit_last;
  logic [7:0]    raw;
  logic [3:0]    cnt_next;
`ifdef TM1638_KEY_EDGE_EN
  logic [7:0]    kp_q, kp_d;
`endif

  // Handshake: bus_req stays high from REQ through READ; bus_gnt is only looked at in REQ,
  // so once granted the scan always runs to completion and the bus is released in DONE.

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= dio_in;
      sync2_q <= sync1_q;
    end
  end

  assign half_end = (tmr_q == HALF_LAST);
  assign bit_last = (state_q == S_CMD) ? 5'd7 : 5'd31;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    half_d  = half_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      S_WAIT: begin
        if (tmr_q == POLL_LAST) begin
          state_d = S_REQ;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_REQ: begin
        if (bus_gnt) begin
          state_d = S_SETUP;
          tmr_d   = '0;
        end
      end
      S_SETUP: begin
        if (half_end) begin
          state_d = S_CMD;
          tmr_d   = '0;
          half_d  = 1'b0;
          bit_d   = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_CMD, S_READ: begin
        if (half_end) begin
          tmr_d = '0;
          if (!half_q) begin
            half_d = 1'b1;
          end else begin
            half_d = 1'b0;
            // Sample on the last cycle of the sclk-high half; first bit ends up in bit 0.
            if (state_q == S_READ) shift_d = {sync2_q, shift_q[31:1]};
            if (bit_q == bit_last) begin
              state_d = (state_q == S_CMD) ? S_TURN : S_DONE;
              bit_d   = '0;
            end else begin
              bit_d = bit_q + 5'd1;
            end
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_TURN: begin
        if (tmr_q == TURN_LAST) begin
          state_d = S_READ;
          tmr_d   = '0;
          half_d  = 1'b0;
          bit_d   = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_DONE: begin
        state_d = S_WAIT;
        tmr_d   = '0;
      end
      default: state_d = S_WAIT;
    endcase
  end

  // Pin values are decoded from the next state and registered, so the pads never glitch.
  always_comb begin
    stb_d  = 1'b1;
    sclk_d = 1'b1;
    oe_d   = 1'b0;
    dout_d = 1'b1;
    req_d  = 1'b0;
    case (state_d)
      S_REQ:   req_d = 1'b1;
      S_SETUP, S_TURN: begin
        stb_d = 1'b0;
        req_d = 1'b1;
      end
      S_CMD: begin
        stb_d  = 1'b0;
        req_d  = 1'b1;
        sclk_d = half_d;
        oe_d   = 1'b1;
        dout_d = CMD_READ[bit_d[2:0]];
      end
      S_READ: begin
        stb_d  = 1'b0;
        req_d  = 1'b1;
        sclk_d = half_d;
      end
      default: ;
    endcase
  end

  assign raw = {shift_q[28], shift_q[20], shift_q[12], shift_q[4],
                shift_q[24], shift_q[16], shift_q[8],  shift_q[0]};

  always_comb begin
    if (raw == prev_raw_q) cnt_next = (cnt_q >= DEB_N) ? DEB_N : cnt_q + 4'd1;
    else                   cnt_next = 4'd1;
  end

  always_comb begin
    prev_raw_d    = prev_raw_q;
    cnt_d         = cnt_q;
    key_d         = key_q;
    key_valid_d   = 1'b0;
    key_changed_d = 1'b0;
`ifdef TM1638_KEY_EDGE_EN
    kp_d          = '0;
`endif
    if (state_q == S_DONE) begin
      prev_raw_d  = raw;
      cnt_d       = cnt_next;
      key_valid_d = 1'b1;
      if (cnt_next == DEB_N && raw != key_q) begin
        key_d         = raw;
        key_changed_d = 1'b1;
`ifdef TM1638_KEY_EDGE_EN
        kp_d          = raw & ~key_q;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_WAIT;
      tmr_q         <= '0;
      half_q        <= 1'b1;
      bit_q         <= '0;
      shift_q       <= '0;
      prev_raw_q    <= '0;
      cnt_q         <= '0;
      key_q         <= '0;
      key_valid_q   <= 1'b0;
      key_changed_q <= 1'b0;
      stb_q         <= 1'b1;
      sclk_q        <= 1'b1;
      dout_q        <= 1'b1;
      oe_q          <= 1'b0;
      req_q         <= 1'b0;
`ifdef TM1638_KEY_EDGE_EN
      kp_q          <= '0;
`endif
    end else begin
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      half_q        <= half_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      prev_raw_q    <= prev_raw_d;
      cnt_q         <= cnt_d;
      key_q         <= key_d;
      key_valid_q   <= key_valid_d;
      key_changed_q <= key_changed_d;
      stb_q         <= stb_d;
      sclk_q        <= sclk_d;
      dout_q        <= dout_d;
      oe_q          <= oe_d;
      req_q         <= req_d;
`ifdef TM1638_KEY_EDGE_EN
      kp_q          <= kp_d;
`endif
    end
  end

  assign bus_req     = req_q;
  assign stb         = stb_q;
  assign sclk        = sclk_q;
  assign dio_out     = dout_q;
  assign dio_oe      = oe_q;
  assign key         = key_q;
  assign key_valid   = key_valid_q;
  assign key_changed = key_changed_q;
  assign dbg_state_o = state_q;
`ifdef TM1638_KEY_EDGE_EN
  assign key_pressed = kp_q;
`endif

endmodule

// File: tb/tb_tm1638_key_reader.sv
// Bench for tm1638_key_reader: TM1638 slave model on the bus, queue-based debounce reference.
module tb_tm1638_key_reader;

  localparam int CLK_DIV       = 4;
  localparam int TURNAROUND    = 8;
  localparam int POLL_INTERVAL = 200;
  localparam int DEB           = 4;
  localparam int XACT          = CLK_DIV + 16 * CLK_DIV + TURNAROUND + 64 * CLK_DIV;
  localparam logic [31:0] IGN_MASK = 32'hEEEE_EEEE;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bus_gnt = 1'b0;
  logic       dio_in = 1'b1;
  logic       bus_req, stb, sclk, dio_out, dio_oe, key_valid, key_changed;
  logic [7:0] key;
  logic [2:0] dbg_state;
`ifdef TM1638_KEY_EDGE_EN
  logic [7:0] key_pressed;
`endif

  always #5 clk = ~clk;

  tm1638_key_reader #(
    .CLK_DIV(CLK_DIV), .TURNAROUND(TURNAROUND),
    .POLL_INTERVAL(POLL_INTERVAL), .DEBOUNCE_SAMPLES(DEB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .stb(stb), .sclk(sclk), .dio_out(dio_out), .dio_oe(dio_oe), .dio_in(dio_in),
    .key(key), .key_valid(key_valid), .key_changed(key_changed),
`ifdef TM1638_KEY_EDGE_EN
    .key_pressed(key_pressed),
`endif
    .dbg_state_o(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- TM1638 slave model ----------------
  logic [31:0] slv_word = '0;
  logic [7:0]  slv_cmd  = '0;
  int          slv_rise = 0;

  initial begin
    forever begin
      @(posedge sclk or negedge sclk or posedge stb);
      if (stb) begin
        slv_rise = 0;
        dio_in   = 1'b1;
      end else if (sclk) begin
        if (slv_rise < 8) slv_cmd[slv_rise] = dio_out;
        slv_rise++;
      end else if (slv_rise >= 8 && slv_rise < 40) begin
        dio_in = slv_word[slv_rise - 8];
      end
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [8:0] exp_q[$];
  logic [7:0] m_hist[$];
  logic [7:0] m_key = '0;

  function automatic logic [7:0] map_keys(input logic [31:0] w);
    logic [7:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i]     = w[8 * i];
      r[i + 4] = w[8 * i + 4];
    end
    return r;
  endfunction

  // Key follows raw once the last DEB completed scans were all identical.
  task automatic model_scan(input logic [31:0] w);
    logic [7:0] r;
    bit stable, chg;
    r = map_keys(w);
    m_hist.push_back(r);
    if (m_hist.size() > DEB) void'(m_hist.pop_front());
    stable = (m_hist.size() == DEB);
    foreach (m_hist[i]) if (m_hist[i] != r) stable = 1'b0;
    chg = stable && (r != m_key);
    if (chg) m_key = r;
    exp_q.push_back({chg, m_key});
  endtask

  task automatic model_reset();
    m_key = '0;
    m_hist.delete();
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_scan(input logic [31:0] w, output bit ok, output logic [7:0] k,
                          output logic kc, output logic [7:0] kp);
    slv_word = w;
    model_scan(w);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (key_valid) begin
        ok = 1'b1;
        break;
      end
    end
    k  = key;
    kc = key_changed;
`ifdef TM1638_KEY_EDGE_EN
    kp = key_pressed;
`else
    kp = 8'h00;
`endif
  endtask

  task automatic wait_req(output int n);
    n = 0;
    for (int i = 0; i < POLL_INTERVAL + 100; i++) begin
      @(negedge clk);
      n++;
      if (bus_req) break;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus_gnt = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    n_checks++;
    if ({stb, sclk, dio_oe, dio_out, bus_req} !== 5'b11010) begin
      n_fail++;
      $display("FAIL reset_pins: stb,sclk,oe,dout,req=%b required 11010",
               {stb, sclk, dio_oe, dio_out, bus_req});
    end
    n_checks++;
    if ({key, key_valid, key_changed} !== 10'h000) begin
      n_fail++;
      $display("FAIL reset_key: key=%h valid=%b chg=%b required 00 0 0", key, key_valid, key_changed);
    end
  endtask

  task automatic test_protocol();
    int n, stb_low, first_low, stb_rise, oe_cnt, oe_last, rd_fall, rises, kv_cnt, kv_c;
    logic prev_sclk;
    logic [7:0] k_at;
    logic kc_at;
    logic [8:0] exp;
    bus_gnt = 1'b1;
    slv_word = '0;
    model_scan(32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_req(n);
    n_checks++;
    if (n != POLL_INTERVAL) begin
      n_fail++;
      $display("FAIL poll_to_req: %0d cycles required %0d", n, POLL_INTERVAL);
    end
    stb_low = 0; first_low = -1; stb_rise = -1; oe_cnt = 0; oe_last = -1; rd_fall = -1;
    rises = 0; kv_cnt = 0; kv_c = -1; prev_sclk = 1'b1; k_at = 'x; kc_at = 'x;
    for (int c = 1; c <= XACT + 10; c++) begin
      @(negedge clk);
      if (!stb) begin
        stb_low++;
        if (first_low < 0) first_low = c;
      end else if (stb_low > 0 && stb_rise < 0) begin
        stb_rise = c;
      end
      if (dio_oe) begin
        oe_cnt++;
        oe_last = c;
      end else if (!stb && !sclk && oe_last > 0 && rd_fall < 0) begin
        rd_fall = c;
      end
      if (sclk && !prev_sclk) rises++;
      prev_sclk = sclk;
      if (key_valid) begin
        kv_cnt++;
        kv_c = c;
        k_at = key;
        kc_at = key_changed;
      end
    end
    n_checks++;
    if (first_low != 1) begin
      n_fail++;
      $display("FAIL stb_fall_latency: cycle %0d required 1", first_low);
    end
    n_checks++;
    if (slv_cmd !== 8'h42) begin
      n_fail++;
      $display("FAIL cmd_byte: %h required 42", slv_cmd);
    end
    n_checks++;
    if (stb_low != XACT || stb_rise != XACT + 1) begin
      n_fail++;
      $display("FAIL xact_len: stb low %0d rise@%0d required %0d rise@%0d", stb_low, stb_rise, XACT, XACT + 1);
    end
    n_checks++;
    if (oe_cnt != 16 * CLK_DIV) begin
      n_fail++;
      $display("FAIL cmd_oe_len: %0d required %0d", oe_cnt, 16 * CLK_DIV);
    end
    n_checks++;
    if (rd_fall - oe_last - 1 != TURNAROUND) begin
      n_fail++;
      $display("FAIL turnaround: %0d required %0d", rd_fall - oe_last - 1, TURNAROUND);
    end
    n_checks++;
    if (rises != 40) begin
      n_fail++;
      $display("FAIL sclk_pulses: %0d required 40", rises);
    end
    n_checks++;
    if (kv_cnt != 1 || kv_c != XACT + 2) begin
      n_fail++;
      $display("FAIL key_valid_pulse: count %0d at %0d required 1 at %0d", kv_cnt, kv_c, XACT + 2);
    end
    exp = exp_q.pop_front();
    n_checks++;
    if ({kc_at, k_at} !== exp) begin
      n_fail++;
      $display("FAIL protocol_key: key=%h chg=%b required key=%h chg=%b", k_at, kc_at, exp[7:0], exp[8]);
    end
  endtask

  task automatic test_alternate();
    bit ok;
    logic [7:0] k, kp;
    logic kc;
    logic [8:0] exp;
    for (int i = 0; i < 6; i++) begin
      run_scan(($urandom & IGN_MASK) | ((i % 2 == 0) ? 32'h1 : 32'h0), ok, k, kc, kp);
      exp = exp_q.pop_front();
      n_checks++;
      if (!ok || {kc, k} !== exp || k !== 8'h00) begin
        n_fail++;
        $display("FAIL alternate scan%0d: ok=%0d key=%h chg=%b required key=%h chg=%b", i, ok, k, kc, exp[7:0], exp[8]);
      end
    end
  endtask

  task automatic test_debounce();
    bit ok;
    logic [7:0] k, kp;
    logic kc;
    logic [8:0] exp;
    for (int i = 0; i < 5; i++) begin
      run_scan(32'h1100_1001, ok, k, kc, kp);
      exp = exp_q.pop_front();
      n_checks++;
      if (!ok || {kc, k} !== exp) begin
        n_fail++;
        $display("FAIL debounce scan%0d: ok=%0d key=%h chg=%b required key=%h chg=%b", i, ok, k, kc, exp[7:0], exp[8]);
      end
      if (i == 3) begin
        n_checks++;
        if (k !== 8'hA9 || kc !== 1'b1) begin
          n_fail++;
          $display("FAIL debounce_update: key=%h chg=%b required a9 1", k, kc);
        end
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [7:0] k, kp;
    logic kc;
    logic [8:0] exp;
    logic [31:0] base;
    base = $urandom;
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 3) == 0) base = $urandom;
      run_scan(base ^ ($urandom & IGN_MASK), ok, k, kc, kp);
      exp = exp_q.pop_front();
      n_checks++;
      if (!ok || {kc, k} !== exp) begin
        n_fail++;
        $display("FAIL random scan%0d: ok=%0d key=%h chg=%b required key=%h chg=%b", i, ok, k, kc, exp[7:0], exp[8]);
      end
    end
  endtask

  task automatic test_gnt_hold();
    int n, bad;
    bit ok;
    logic [8:0] exp;
    bus_gnt = 1'b0;
    slv_word = $urandom;
    model_scan(slv_word);
    wait_req(n);
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (stb !== 1'b1 || sclk !== 1'b1 || bus_req !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0 || n != POLL_INTERVAL) begin
      n_fail++;
      $display("FAIL gnt_hold_idle: %0d bad cycles, req after %0d required 0 and %0d", bad, n, POLL_INTERVAL);
    end
    bus_gnt = 1'b1;
    @(negedge clk);
    n_checks++;
    if (stb !== 1'b0) begin
      n_fail++;
      $display("FAIL gnt_start: stb=%b required 0", stb);
    end
    repeat (100) @(negedge clk);
    bus_gnt = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (key_valid) begin
        ok = 1'b1;
        break;
      end
    end
    exp = exp_q.pop_front();
    n_checks++;
    if (!ok || {key_changed, key} !== exp || bus_req !== 1'b0 || stb !== 1'b1) begin
      n_fail++;
      $display("FAIL gnt_drop_scan: ok=%0d key=%h chg=%b req=%b required key=%h chg=%b req=0",
               ok, key, key_changed, bus_req, exp[7:0], exp[8]);
    end
    bus_gnt = 1'b1;
  endtask

  task automatic test_reset_mid_read();
    bit ok, hit;
    int n;
    logic [7:0] k, kp;
    logic kc;
    logic [8:0] exp;
    for (int i = 0; i < DEB; i++) begin
      run_scan(32'h0000_0011, ok, k, kc, kp);
      exp = exp_q.pop_front();
      n_checks++;
      if (!ok || {kc, k} !== exp) begin
        n_fail++;
        $display("FAIL preload scan%0d: ok=%0d key=%h chg=%b required key=%h chg=%b", i, ok, k, kc, exp[7:0], exp[8]);
      end
    end
    slv_word = $urandom;
    hit = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!stb && !sclk && slv_rise == 20) begin
        hit = 1'b1;
        break;
      end
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (!hit || {stb, sclk, dio_oe, dio_out, bus_req} !== 5'b11010 || key !== 8'h00 || key_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_read: reached=%0d pins=%b key=%h valid=%b required 1 11010 00 0",
               hit, {stb, sclk, dio_oe, dio_out, bus_req}, key, key_valid);
    end
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    wait_req(n);
    n_checks++;
    if (n != POLL_INTERVAL) begin
      n_fail++;
      $display("FAIL reset_repoll: %0d cycles required %0d", n, POLL_INTERVAL);
    end
    run_scan(slv_word, ok, k, kc, kp);
    exp = exp_q.pop_front();
    n_checks++;
    if (!ok || {kc, k} !== exp) begin
      n_fail++;
      $display("FAIL post_reset_scan: ok=%0d key=%h chg=%b required key=%h chg=%b", ok, k, kc, exp[7:0], exp[8]);
    end
  endtask

`ifdef TM1638_KEY_EDGE_EN
  task automatic test_edge();
    bit ok;
    logic [7:0] k, kp, old, exp_kp;
    logic kc;
    logic [8:0] exp;
    logic [31:0] pat[3];
    pat[0] = 32'h0000_0001;
    pat[1] = 32'h0000_0101;
    pat[2] = 32'h0000_0001;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < DEB; i++) begin
        old = m_key;
        run_scan(pat[p], ok, k, kc, kp);
        exp = exp_q.pop_front();
        exp_kp = exp[8] ? (exp[7:0] & ~old) : 8'h00;
        n_checks++;
        if (!ok || {kc, k} !== exp || kp !== exp_kp) begin
          n_fail++;
          $display("FAIL edge p%0d s%0d: key=%h chg=%b pressed=%h required key=%h chg=%b pressed=%h",
                   p, i, k, kc, kp, exp[7:0], exp[8], exp_kp);
        end
      end
    end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_protocol();
    test_alternate();
    test_debounce();
    test_random();
    test_gnt_hold();
    test_reset_mid_read();
`ifdef TM1638_KEY_EDGE_EN
    test_edge();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
